vga_rx: RTL and testbench
=========================

VGA_RX -- requirements
Module: vga_rx

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- H_DISP, 640, active pixels per line
- H_TOTAL, 800, pixel ticks per line
- H_BACK, 48, ticks from hsync deassertion to first active pixel
- V_DISP, 480, active lines per frame
- V_TOTAL, 525, lines per frame
- V_BACK, 10, hsync deassertions from vsync deassertion to first active line
- SYNC_ACT, 1'b1, asserted level of hsync/vsync
REQ-002 Ports (name, direction, width, meaning), one per line:
- clk, in, 1, system clock; one clock, reset is synchronous and active-high
- reset, in, 1, synchronous active-high reset
- p_tick, in, 1, pixel-rate enable; all video inputs sampled only when high
- hsync, in, 1, horizontal sync
- vsync, in, 1, vertical sync
- rgb, in, 3, pixel colour
- pix_valid, out, 1, one-cycle strobe per active pixel
- pix_x, out, 10, column of the strobed pixel
- pix_y, out, 10, row of the strobed pixel
- pix_rgb, out, 3, colour of the strobed pixel
- locked, out, 1, timing locked
- sync_err, out, 1, one-cycle pulse on loss of lock
- frame_done, out, 1, one-cycle pulse when frame_sum updates
- frame_sum, out, 22, sum of pix_rgb over the last complete frame

Function
REQ-003 Sync edges are detected on successive p_tick samples; "H-edge" and "V-edge" denote the sample where hsync/vsync first reads not-SYNC_ACT.
REQ-004 hcnt (10 bit) is loaded with 0 on an H-edge and otherwise increments on each p_tick, saturating at 1023.
REQ-005 vcnt (10 bit) is loaded with 0 on a V-edge and increments on each H-edge; on a same-sample V-edge and H-edge, vcnt loads 1.
REQ-006 A sample is active when H_BACK <= hcnt < H_BACK+H_DISP and V_BACK <= vcnt < V_BACK+V_DISP, with pix_x = hcnt-H_BACK and pix_y = vcnt-V_BACK.
REQ-007 pix_valid/pix_x/pix_y/pix_rgb are registered and appear exactly one clk after the active p_tick sample; pix_valid is high only in LOCKED.
REQ-008 States are SEARCH, ALIGN, LOCKED: SEARCH -> ALIGN on a V-edge; ALIGN -> LOCKED on the next V-edge if vcnt == V_TOTAL and no line error occurred in between, otherwise ALIGN restarts.
REQ-009 Line error: an H-edge with hcnt != H_TOTAL-1, or hcnt reaching 1023; frame error: a V-edge with vcnt != V_TOTAL.
REQ-010 In LOCKED, a line or frame error moves the FSM to SEARCH and pulses sync_err one clk; locked = (state == LOCKED), registered.
REQ-011 The accumulator adds pix_rgb (zero-extended) on each pix_valid; the accumulator clears on every V-edge and on every exit from LOCKED.
REQ-012 On the pix_valid of pixel (H_DISP-1, V_DISP-1), frame_sum is loaded with the final total (including that pixel) one clk later, frame_done pulses that same clk, and the accumulator clears.
REQ-013 The 22-bit sum cannot overflow (7*640*480 < 2^22); no wrap handling is required.
REQ-014 When p_tick is low, no state, counter, or accumulator changes occur; output pulses last exactly one clk.

Reset
REQ-015 reset, sampled on clk, forces SEARCH, hcnt = vcnt = 0, sampled syncs = not-SYNC_ACT, the accumulator and frame_sum to 0, and pix_valid/pix_x/pix_y/pix_rgb/locked/sync_err/frame_done to 0.
REQ-016 Reset asserted mid-frame discards the partial sum; relock requires two further V-edges.

Structure
REQ-017 The 640x480 timing constants and the state encoding belong in the shared VGA package used with vga_sync.
REQ-018 One sub-module is required: vga_edge_det, a p_tick-gated deassertion-edge detector instantiated once each for hsync and vsync.

Verification
REQ-019 Drive from a vga_sync model with constant rgb=3'b110 for 3 frames -> locked rises at the 2nd V-edge; frame_done pulses once in frame 3 with frame_sum = 1,843,200.
REQ-020 Locked, with a ramp source rgb = pix_x[2:0] -> pix_valid count per frame = 307,200; first strobe (0,0,rgb=0); last strobe (639,479,rgb=7).
REQ-021 Locked, stretch one line to 801 ticks -> sync_err pulses once, locked falls, no frame_done for that frame, and lock is regained after 2 clean V-edges.
REQ-022 Locked, with a frame of 524 lines -> sync_err pulses at the V-edge.
REQ-023 Assert reset for 1 clk at pixel (320,240) -> all outputs are 0 next clk; the next frame_done does not occur before the 2nd following frame.
REQ-024 p_tick held low for 1000 clks while locked -> no output changes and no errors.

Source files
------------

// File: rtl/vga_rx_pkg.sv
// vga_rx_pkg: 640x480 timing constants, receiver state encoding and a window helper shared with vga_sync
package vga_rx_pkg;
    localparam int VGA_H_DISP  = 640;
    localparam int VGA_H_TOTAL = 800;
    localparam int VGA_H_BACK  = 48;
    localparam int VGA_V_DISP  = 480;
    localparam int VGA_V_TOTAL = 525;
    localparam int VGA_V_BACK  = 10;

    typedef enum logic [1:0] {SEARCH, ALIGN, LOCKED} state_e;

    function automatic logic in_win(input logic [9:0] val, input logic [9:0] lo, input logic [9:0] hi);
        return val >= lo && val < hi;
    endfunction
endpackage

// File: rtl/vga_edge_det.sv
// vga_edge_det: flags the p_tick sample where a sync line first reads its inactive level
module vga_edge_det #(
    parameter logic ACT = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic p_tick_i,
    input  logic sync_i,
    output logic edge_o
);
    logic sync_q;

    always_ff @(posedge clk) begin
        if (reset) sync_q <= ~ACT;
        else if (p_tick_i) sync_q <= sync_i;
    end

    assign edge_o = p_tick_i && sync_q == ACT && sync_i != ACT;
endmodule

// File: rtl/vga_rx.sv
// vga_rx: locks onto VGA sync timing, strobes active pixels and reports each complete frame's colour sum
module vga_rx
    import vga_rx_pkg::*;
#(
    parameter int   H_DISP   = VGA_H_DISP,
    parameter int   H_TOTAL  = VGA_H_TOTAL,
    parameter int   H_BACK   = VGA_H_BACK,
    parameter int   V_DISP   = VGA_V_DISP,
    parameter int   V_TOTAL  = VGA_V_TOTAL,
    parameter int   V_BACK   = VGA_V_BACK,
    parameter logic SYNC_ACT = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        p_tick,
    input  logic        hsync,
    input  logic        vsync,
    input  logic [2:0]  rgb,
    output logic        pix_valid,
    output logic [9:0]  pix_x,
    output logic [9:0]  pix_y,
    output logic [2:0]  pix_rgb,
    output logic        locked,
    output logic        sync_err,
    output logic        frame_done,
    output logic [21:0] frame_sum
);
    localparam logic [9:0] H_BEG   = 10'(H_BACK);
    localparam logic [9:0] H_END   = 10'(H_BACK + H_DISP);
    localparam logic [9:0] H_LAST  = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_BEG   = 10'(V_BACK);
    localparam logic [9:0] V_END   = 10'(V_BACK + V_DISP);
    localparam logic [9:0] V_TOT   = 10'(V_TOTAL);
    localparam logic [9:0] X_LAST  = 10'(H_DISP - 1);
    localparam logic [9:0] Y_LAST  = 10'(V_DISP - 1);
    localparam logic [9:0] CNT_MAX = '1;

    state_e      state_q, state_d;
    logic [9:0]  hcnt_q, hcnt_d, vcnt_q, vcnt_d;
    logic        line_bad_q, line_bad_d;
    logic [21:0] acc_q, acc_d;
    logic        h_edge, v_edge, line_err, frame_err, active, lose, last;

    vga_edge_det #(.ACT(SYNC_ACT)) u_hedge (
        .clk(clk), .reset(reset), .p_tick_i(p_tick), .sync_i(hsync), .edge_o(h_edge)
    );
    vga_edge_det #(.ACT(SYNC_ACT)) u_vedge (
        .clk(clk), .reset(reset), .p_tick_i(p_tick), .sync_i(vsync), .edge_o(v_edge)
    );

    assign hcnt_d = !p_tick ? hcnt_q : h_edge ? '0 : hcnt_q == CNT_MAX ? hcnt_q : hcnt_q + 10'd1;
    // a line ending on the same sample as the frame already counts toward the new frame
    assign vcnt_d = !p_tick ? vcnt_q : v_edge ? {9'd0, h_edge} : h_edge ? vcnt_q + 10'd1 : vcnt_q;

    assign line_err  = p_tick && ((h_edge && hcnt_q != H_LAST) || hcnt_q == CNT_MAX);
    assign frame_err = v_edge && vcnt_q != V_TOT;
    assign active    = p_tick && in_win(hcnt_q, H_BEG, H_END) && in_win(vcnt_q, V_BEG, V_END);
    assign last      = pix_valid && pix_x == X_LAST && pix_y == Y_LAST;
    assign acc_d     = (v_edge || lose || last) ? '0 : pix_valid ? acc_q + 22'(pix_rgb) : acc_q;
    assign locked    = state_q == LOCKED;

    always_comb begin
        state_d    = state_q;
        line_bad_d = line_bad_q;
        lose       = 1'b0;
        unique case (state_q)
            SEARCH: if (v_edge) begin
                state_d    = ALIGN;
                line_bad_d = 1'b0;
            end
            ALIGN: if (v_edge) begin
                state_d    = (vcnt_q == V_TOT && !line_bad_q && !line_err) ? LOCKED : ALIGN;
                line_bad_d = 1'b0;
            end else if (line_err) line_bad_d = 1'b1;
            LOCKED: if (line_err || frame_err) begin
                state_d = SEARCH;
                lose    = 1'b1;
            end
            default: state_d = SEARCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= SEARCH;
            line_bad_q <= 1'b0;
            hcnt_q     <= '0;
            vcnt_q     <= '0;
            acc_q      <= '0;
            frame_sum  <= '0;
            frame_done <= 1'b0;
            sync_err   <= 1'b0;
            pix_valid  <= 1'b0;
            pix_x      <= '0;
            pix_y      <= '0;
            pix_rgb    <= '0;
        end else begin
            state_q    <= state_d;
            line_bad_q <= line_bad_d;
            hcnt_q     <= hcnt_d;
            vcnt_q     <= vcnt_d;
            acc_q      <= acc_d;
            frame_sum  <= last ? acc_q + 22'(pix_rgb) : frame_sum;
            frame_done <= last;
            sync_err   <= lose;
            pix_valid  <= active && state_q == LOCKED;
            if (active) begin
                pix_x   <= hcnt_q - H_BEG;
                pix_y   <= vcnt_q - V_BEG;
                pix_rgb <= rgb;
            end
        end
    end
endmodule

// File: tb/tb_vga_rx.sv
// tb_vga_rx: drives a scaled-down VGA source frame by frame and checks strobes, lock, errors and frame sums
module tb_vga_rx;
    localparam int HD = 8, HT = 20, HB = 4, VD = 6, VT = 12, VB = 2;
    localparam int HS = HD + 1, HE = HT - HB - 1, VS = VD + 2, VE = VT - VB;

    logic        clk = 1'b0, reset = 1'b1, p_tick = 1'b0, hsync = 1'b0, vsync = 1'b0;
    logic [2:0]  rgb = '0;
    logic        pix_valid, locked, sync_err, frame_done;
    logic [9:0]  pix_x, pix_y;
    logic [2:0]  pix_rgb;
    logic [21:0] frame_sum;

    vga_rx #(
        .H_DISP(HD), .H_TOTAL(HT), .H_BACK(HB), .V_DISP(VD), .V_TOTAL(VT), .V_BACK(VB), .SYNC_ACT(1'b1)
    ) dut (
        .clk(clk), .reset(reset), .p_tick(p_tick), .hsync(hsync), .vsync(vsync), .rgb(rgb),
        .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y), .pix_rgb(pix_rgb), .locked(locked),
        .sync_err(sync_err), .frame_done(frame_done), .frame_sum(frame_sum)
    );

    always #5 clk = ~clk;

    typedef struct {
        int act;
        bit ramp;
        int nv;
        int nd;
        int ne;
        bit lk;
        int sum;
    } row_t;

    row_t        rows [14];
    int          total = 0, bad = 0;
    int          h = 0, v = 0, drv_h = 0, drv_v = 0;
    logic [2:0]  drv_rgb = '0;
    bit          ramp = 1'b0;
    int          n_valid, n_done, n_err;
    logic [21:0] got_sum;
    logic [22:0] first_s, last_s;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, got, exp);
        end
    endtask

    task automatic observe();
        logic tk;
        tk = p_tick;
        @(posedge clk);
        @(negedge clk);
        if (pix_valid) begin
            check("strobe", {tk, pix_x, pix_y, pix_rgb}, {1'b1, 10'(drv_h), 10'(drv_v), drv_rgb});
            check("strobe_window", 64'(drv_h < HD && drv_v < VD), 64'd1);
            if (n_valid == 0) first_s = {pix_x, pix_y, pix_rgb};
            last_s = {pix_x, pix_y, pix_rgb};
            n_valid++;
        end
        if (frame_done) begin
            n_done++;
            got_sum = frame_sum;
        end
        if (sync_err) n_err++;
    endtask

    task automatic tick();
        hsync   = h >= HS && h < HE;
        vsync   = v >= VS && v < VE;
        drv_h   = h;
        drv_v   = v;
        drv_rgb = ramp ? 3'(h) : 3'd6;
        rgb     = drv_rgb;
        p_tick  = 1'b1;
        observe();
        if (reset) begin
            check("reset_mid_frame", {pix_valid, pix_x, pix_y, pix_rgb, locked, sync_err, frame_done, frame_sum}, '0);
            reset = 1'b0;
        end
        p_tick = 1'b0;
        observe();
    endtask

    task automatic pause();
        logic [48:0] snap;
        int          chg = 0;
        snap = {pix_valid, pix_x, pix_y, pix_rgb, locked, sync_err, frame_done, frame_sum};
        for (int i = 0; i < 1000; i++) begin
            hsync = 1'($urandom);
            vsync = 1'($urandom);
            rgb   = 3'($urandom);
            @(posedge clk);
            @(negedge clk);
            if ({pix_valid, pix_x, pix_y, pix_rgb, locked, sync_err, frame_done, frame_sum} != snap) chg++;
        end
        check("pause_stable", 64'(chg), 64'd0);
    endtask

    task automatic run_frame(input int act);
        n_valid = 0;
        n_done  = 0;
        n_err   = 0;
        got_sum = '0;
        do begin
            if (act == 3 && v == 3 && h == 4) reset = 1'b1;
            if (act == 4 && v == 2 && h == 2) pause();
            tick();
            h++;
            if (h == ((act == 1 && v == VE) ? HT + 1 : HT)) begin
                h = 0;
                v = (v == VT - 1) ? 0 : (act == 2 && v == VD) ? v + 2 : v + 1;
            end
        end while (h != 0 || v != VE);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: sim_time=%0t limit=1000000", $time);
        $fatal(1);
    end

    initial begin
        // act: 0 clean, 1 first line 1 tick long, 2 one line short, 3 reset at pixel (4,3), 4 p_tick pause
        rows = '{
            '{0, 1'b0,  0, 0, 0, 1'b0,   0},
            '{0, 1'b0, 48, 1, 0, 1'b1, 288},
            '{0, 1'b1, 48, 1, 0, 1'b1, 168},
            '{1, 1'b0,  0, 0, 1, 1'b0,   0},
            '{0, 1'b0,  0, 0, 0, 1'b0,   0},
            '{0, 1'b1, 48, 1, 0, 1'b1, 168},
            '{2, 1'b0, 48, 1, 0, 1'b1, 288},
            '{0, 1'b0,  0, 0, 1, 1'b0,   0},
            '{0, 1'b1,  0, 0, 0, 1'b0,   0},
            '{0, 1'b1, 48, 1, 0, 1'b1, 168},
            '{3, 1'b0, 28, 0, 0, 1'b0,   0},
            '{0, 1'b0,  0, 0, 0, 1'b0,   0},
            '{0, 1'b0, 48, 1, 0, 1'b1, 288},
            '{4, 1'b1, 48, 1, 0, 1'b1, 168}
        };
        repeat (3) @(negedge clk);
        check("reset_state", {pix_valid, pix_x, pix_y, pix_rgb, locked, sync_err, frame_done, frame_sum}, '0);
        reset = 1'b0;
        run_frame(0);
        check("preroll valid", 64'(n_valid), 64'd0);
        check("preroll locked", 64'(locked), 64'd0);
        for (int i = 0; i < 14; i++) begin
            ramp = rows[i].ramp;
            run_frame(rows[i].act);
            check($sformatf("row%0d valid", i), 64'(n_valid), 64'(rows[i].nv));
            check($sformatf("row%0d done", i), 64'(n_done), 64'(rows[i].nd));
            check($sformatf("row%0d err", i), 64'(n_err), 64'(rows[i].ne));
            check($sformatf("row%0d locked", i), 64'(locked), 64'(rows[i].lk));
            if (rows[i].nd > 0) check($sformatf("row%0d sum", i), 64'(got_sum), 64'(rows[i].sum));
            if (rows[i].nv == HD * VD) begin
                check($sformatf("row%0d first", i), 64'(first_s), {41'd0, 10'd0, 10'd0, rows[i].ramp ? 3'd0 : 3'd6});
                check($sformatf("row%0d last", i), 64'(last_s), {41'd0, 10'(HD - 1), 10'(VD - 1), rows[i].ramp ? 3'd7 : 3'd6});
            end
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
